// File: rtl/cpu_pkg.sv
// cpu_pkg -- definitions shared by the control sequencer and the datapath.
//
// Contents:
//   OPW, ALU_OPW    opcode and ALU-select widths
//   OP_*            opcode values (IR[31:27])
//   ALU_*           ALU operation codes
//   state_t         sequencer states RESET, T0..T7, HALT
//   iclass_t        decoded instruction class
//   *_IDX           bit positions inside the Gsel/Rctl/PCctl/MEMctl/Zctl vectors
//   ctrl_t          bundle of every registered control output
package cpu_pkg;

  localparam int OPW     = 5;
  localparam int ALU_OPW = 4;

  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  localparam logic [ALU_OPW-1:0] ALU_ADD = 4'd0;
  localparam logic [ALU_OPW-1:0] ALU_SUB = 4'd1;
  localparam logic [ALU_OPW-1:0] ALU_AND = 4'd2;
  localparam logic [ALU_OPW-1:0] ALU_OR  = 4'd3;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU_R, CLS_ALU_I, CLS_LDI, CLS_LD, CLS_ST, CLS_NOP, CLS_HALT, CLS_BAD
  } iclass_t;

  // Gsel = {Gra,Grb,Grc}
  localparam int GRA_IDX = 2;
  localparam int GRB_IDX = 1;
  localparam int GRC_IDX = 0;
  // Rctl = {Rin,Rout,BAout}
  localparam int RIN_IDX   = 2;
  localparam int ROUT_IDX  = 1;
  localparam int BAOUT_IDX = 0;
  // PCctl = {PCout,PCin,IncPC}
  localparam int PCOUT_IDX = 2;
  localparam int PCIN_IDX  = 1;
  localparam int INCPC_IDX = 0;
  // MEMctl = {MARin,MDRin,MDRout,Read,Write}
  localparam int MARIN_IDX  = 4;
  localparam int MDRIN_IDX  = 3;
  localparam int MDROUT_IDX = 2;
  localparam int READ_IDX   = 1;
  localparam int WRITE_IDX  = 0;
  // Zctl = {Yin,Zin,Zlowout}
  localparam int YIN_IDX   = 2;
  localparam int ZIN_IDX   = 1;
  localparam int ZLOW_IDX  = 0;

  typedef struct packed {
    logic               run;
    logic [2:0]         gsel;
    logic [2:0]         rctl;
    logic               cout;
    logic [2:0]         pcctl;
    logic [4:0]         memctl;
    logic [2:0]         zctl;
    logic               irin;
    logic [ALU_OPW-1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if -- instruction/handshake inputs and control strobes
// between the control sequencer and the datapath.
//
//   IR, Mem_ready, Stop        datapath -> sequencer
//   Run, Gsel, Rctl, Cout,
//   PCctl, MEMctl, Zctl, IRin,
//   ALU_op, Illegal            sequencer -> datapath
//
// Modports: master = sequencer side, slave = datapath side.
interface control_sequencer_if;
  import cpu_pkg::*;

  logic [31:0]        IR;
  logic               Mem_ready;
  logic               Stop;
  logic               Run;
  logic [2:0]         Gsel;
  logic [2:0]         Rctl;
  logic               Cout;
  logic [2:0]         PCctl;
  logic [4:0]         MEMctl;
  logic [2:0]         Zctl;
  logic               IRin;
  logic [ALU_OPW-1:0] ALU_op;
  logic               Illegal;

  modport master (
    input  IR, Mem_ready, Stop,
    output Run, Gsel, Rctl, Cout, PCctl, MEMctl, Zctl, IRin, ALU_op, Illegal
  );

  modport slave (
    output IR, Mem_ready, Stop,
    input  Run, Gsel, Rctl, Cout, PCctl, MEMctl, Zctl, IRin, ALU_op, Illegal
  );

endinterface

// File: rtl/control_sequencer_op_decode.sv
// op_decode -- combinational opcode classifier.
//
//   opcode  in   IR[31:27]
//   iclass  out  instruction class (register ALU, immediate ALU, ldi, ld,
//                st, nop, halt, or BAD for anything undefined)
//   alu_op  out  ALU operation for ALU-class instructions, ADD otherwise
module op_decode
  import cpu_pkg::*;
(
  input  logic [OPW-1:0]     opcode,
  output iclass_t            iclass,
  output logic [ALU_OPW-1:0] alu_op
);

  // Undefined opcodes fall through to BAD so the sequencer can halt on them.
  always_comb begin
    iclass = CLS_BAD;
    alu_op = ALU_ADD;
    case (opcode)
      OP_LD:   iclass = CLS_LD;
      OP_LDI:  iclass = CLS_LDI;
      OP_ST:   iclass = CLS_ST;
      OP_ADD:  iclass = CLS_ALU_R;
      OP_SUB:  begin iclass = CLS_ALU_R; alu_op = ALU_SUB; end
      OP_AND:  begin iclass = CLS_ALU_R; alu_op = ALU_AND; end
      OP_OR:   begin iclass = CLS_ALU_R; alu_op = ALU_OR;  end
      OP_ADDI: iclass = CLS_ALU_I;
      OP_ANDI: begin iclass = CLS_ALU_I; alu_op = ALU_AND; end
      OP_ORI:  begin iclass = CLS_ALU_I; alu_op = ALU_OR;  end
      OP_NOP:  iclass = CLS_NOP;
      OP_HALT: iclass = CLS_HALT;
      default: iclass = CLS_BAD;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer -- multi-cycle Moore control unit for the RISC datapath.
//
//   clock    in   rising-edge clock
//   reset_n  in   asynchronous active-low reset; clears state and every strobe
//   bus      master modport of control_sequencer_if (IR, Mem_ready, Stop in;
//            all G/R, PC, MEM, Y/Z, IR-load and ALU strobes, Run, Illegal out)
//
// Outputs are registered: each edge loads the control word belonging to the
// state being entered, so strobes are glitch-free and drop as soon as reset
// is asserted.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  control_sequencer_if.master  bus
);

  state_t             state, next_state;
  iclass_t            dec_class, cls_q, cls_use;
  logic [ALU_OPW-1:0] dec_alu, alu_q, alu_use;
  ctrl_t              ctrl_q, ctrl_next;
  logic               illegal_q;

  op_decode u_op_decode (
    .opcode (bus.IR[31:27]),
    .iclass (dec_class),
    .alu_op (dec_alu)
  );

  // Control word for a given state. 'fresh' is low while T1 is being
  // re-entered during a fetch wait so PCin is pulsed only once.
  function automatic ctrl_t ctrl_for(input state_t s, input iclass_t c,
                                     input logic [ALU_OPW-1:0] alu,
                                     input logic fresh);
    ctrl_t o;
    o     = '0;
    o.run = (s != S_RESET) && (s != S_HALT);
    case (s)
      S_T0: begin
        o.pcctl[PCOUT_IDX]  = 1'b1;
        o.pcctl[INCPC_IDX]  = 1'b1;
        o.memctl[MARIN_IDX] = 1'b1;
        o.zctl[ZIN_IDX]     = 1'b1;
        o.alu_op            = ALU_ADD;
      end
      S_T1: begin
        o.zctl[ZLOW_IDX]    = 1'b1;
        o.pcctl[PCIN_IDX]   = fresh;
        o.memctl[READ_IDX]  = 1'b1;
        o.memctl[MDRIN_IDX] = 1'b1;
      end
      S_T2: begin
        o.memctl[MDROUT_IDX] = 1'b1;
        o.irin               = 1'b1;
      end
      S_T3: begin
        if (c inside {CLS_ALU_R, CLS_ALU_I, CLS_LDI, CLS_LD, CLS_ST}) begin
          o.gsel[GRB_IDX] = 1'b1;
          o.zctl[YIN_IDX] = 1'b1;
          if (c inside {CLS_ALU_R, CLS_ALU_I}) o.rctl[ROUT_IDX]  = 1'b1;
          else                                 o.rctl[BAOUT_IDX] = 1'b1;
        end
      end
      S_T4: begin
        case (c)
          CLS_ALU_R: begin
            o.gsel[GRC_IDX]  = 1'b1;
            o.rctl[ROUT_IDX] = 1'b1;
            o.alu_op         = alu;
            o.zctl[ZIN_IDX]  = 1'b1;
          end
          CLS_ALU_I: begin
            o.cout          = 1'b1;
            o.alu_op        = alu;
            o.zctl[ZIN_IDX] = 1'b1;
          end
          CLS_LDI, CLS_LD, CLS_ST: begin
            o.cout          = 1'b1;
            o.alu_op        = ALU_ADD;
            o.zctl[ZIN_IDX] = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        o.zctl[ZLOW_IDX] = 1'b1;
        if (c inside {CLS_LD, CLS_ST}) begin
          o.memctl[MARIN_IDX] = 1'b1;
        end else begin
          o.gsel[GRA_IDX] = 1'b1;
          o.rctl[RIN_IDX] = 1'b1;
        end
      end
      S_T6: begin
        o.memctl[MDRIN_IDX] = 1'b1;
        if (c == CLS_ST) begin
          // Store data comes from Ra over the bus, not from memory.
          o.gsel[GRA_IDX]  = 1'b1;
          o.rctl[ROUT_IDX] = 1'b1;
        end else begin
          o.memctl[READ_IDX] = 1'b1;
        end
      end
      S_T7: begin
        if (c == CLS_ST) begin
          o.memctl[WRITE_IDX] = 1'b1;
        end else begin
          o.memctl[MDROUT_IDX] = 1'b1;
          o.gsel[GRA_IDX]      = 1'b1;
          o.rctl[RIN_IDX]      = 1'b1;
        end
      end
      default: ;
    endcase
    return o;
  endfunction

  // Leaving T2 the class comes straight from the decoder, since that is the
  // edge at which it gets latched; afterwards the latched copy is used.
  always_comb begin
    cls_use = (state == S_T2) ? dec_class : cls_q;
    alu_use = (state == S_T2) ? dec_alu   : alu_q;
  end

  // Sequencing rules. Stop is only looked at on the last step of an
  // instruction; memory steps hold until Mem_ready is sampled high.
  always_comb begin
    next_state = state;
    case (state)
      S_RESET: next_state = S_T0;
      S_T0:    next_state = S_T1;
      S_T1:    if (bus.Mem_ready) next_state = S_T2;
      S_T2:    next_state = S_T3;
      S_T3: begin
        case (cls_q)
          CLS_NOP:           next_state = bus.Stop ? S_HALT : S_T0;
          CLS_HALT, CLS_BAD: next_state = S_HALT;
          default:           next_state = S_T4;
        endcase
      end
      S_T4:    next_state = S_T5;
      S_T5: begin
        if (cls_q inside {CLS_LD, CLS_ST}) next_state = S_T6;
        else                               next_state = bus.Stop ? S_HALT : S_T0;
      end
      S_T6:    if (cls_q == CLS_ST || bus.Mem_ready) next_state = S_T7;
      S_T7: begin
        if (cls_q == CLS_LD || bus.Mem_ready)
          next_state = bus.Stop ? S_HALT : S_T0;
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_RESET;
    endcase
  end

  always_comb ctrl_next = ctrl_for(next_state, cls_use, alu_use, state != S_T1);

  // State register, latched opcode class, registered strobes and the sticky
  // Illegal flag, which rises together with the T3 of an undefined opcode.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_RESET;
      cls_q     <= CLS_NOP;
      alu_q     <= ALU_ADD;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state  <= next_state;
      ctrl_q <= ctrl_next;
      if (state == S_T2) begin
        cls_q <= dec_class;
        alu_q <= dec_alu;
        if (dec_class == CLS_BAD) illegal_q <= 1'b1;
      end
    end
  end

  assign bus.Run     = ctrl_q.run;
  assign bus.Gsel    = ctrl_q.gsel;
  assign bus.Rctl    = ctrl_q.rctl;
  assign bus.Cout    = ctrl_q.cout;
  assign bus.PCctl   = ctrl_q.pcctl;
  assign bus.MEMctl  = ctrl_q.memctl;
  assign bus.Zctl    = ctrl_q.zctl;
  assign bus.IRin    = ctrl_q.irin;
  assign bus.ALU_op  = ctrl_q.alu_op;
  assign bus.Illegal = illegal_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer -- self-checking bench for control_sequencer.
// A schedule of expected per-cycle control words is built from each
// instruction's micro-step list, then replayed against the DUT one cycle
// per entry while the matching Mem_ready/Stop/IR values are driven.
module tb_control_sequencer;

  logic clock;
  logic reset_n;
  int   total;
  int   bad;

  control_sequencer_if bus();

  control_sequencer dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One cycle of expected behaviour: control word plus the inputs to drive.
  typedef struct {
    logic [23:0] w;
    logic [31:0] ir;
    logic        mr;
    logic        stop;
  } step_t;

  step_t sched[$];

  // Word layout {Run,Gsel,Rctl,Cout,PCctl,MEMctl,Zctl,IRin,ALU_op}; PCin is bit 14.
  function automatic logic [23:0] cw(input logic [2:0] g, input logic [2:0] r,
                                     input logic c, input logic [2:0] pc,
                                     input logic [4:0] m, input logic [2:0] z,
                                     input logic irin, input logic [3:0] alu);
    return {1'b1, g, r, c, pc, m, z, irin, alu};
  endfunction

  function automatic logic [23:0] observed();
    return {bus.Run, bus.Gsel, bus.Rctl, bus.Cout, bus.PCctl, bus.MEMctl,
            bus.Zctl, bus.IRin, bus.ALU_op};
  endfunction

  // 0 reg ALU, 1 imm ALU, 2 ldi, 3 ld, 4 st, 5 nop, 6 halt, 7 undefined
  function automatic int class_of(input logic [4:0] op);
    case (op)
      5'd3, 5'd4, 5'd5, 5'd6: return 0;
      5'd12, 5'd13, 5'd14:    return 1;
      5'd1:  return 2;
      5'd0:  return 3;
      5'd2:  return 4;
      5'd26: return 5;
      5'd27: return 6;
      default: return 7;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input logic [4:0] op);
    case (op)
      5'd4:         return 4'd1;
      5'd5, 5'd13:  return 4'd2;
      5'd6, 5'd14:  return 4'd3;
      default:      return 4'd0;
    endcase
  endfunction

  // Appends one micro-step, repeated for every low Mem_ready sample. Stop is
  // random except on the final sample of the final step.
  task automatic add_step(input logic [23:0] w, input logic [31:0] ir,
                          input int waits, input bit is_final,
                          input logic stop_last, input bit fetch);
    step_t s;
    for (int i = 0; i <= waits; i++) begin
      s.w  = w;
      if (fetch && i > 0) s.w[14] = 1'b0;
      s.ir = ir;
      s.mr = (i == waits);
      s.stop = (is_final && i == waits) ? stop_last : logic'($urandom_range(0, 1));
      sched.push_back(s);
    end
  endtask

  task automatic add_idle(input int n);
    step_t s;
    for (int i = 0; i < n; i++) begin
      s.w = '0; s.ir = 32'h0; s.mr = 1'b1; s.stop = logic'($urandom_range(0, 1));
      sched.push_back(s);
    end
  endtask

  task automatic build_instr(input logic [31:0] ir, input int fetch_waits,
                             input int mem_waits, input logic stop_last,
                             output bit halted);
    int k;
    logic [3:0] alu;
    k   = class_of(ir[31:27]);
    alu = alu_of(ir[31:27]);
    add_step(cw(3'b000, 3'b000, 0, 3'b101, 5'b10000, 3'b010, 0, 4'd0), ir, 0, 0, 0, 0);
    add_step(cw(3'b000, 3'b000, 0, 3'b010, 5'b01010, 3'b001, 0, 4'd0), ir, fetch_waits, 0, 0, 1);
    add_step(cw(3'b000, 3'b000, 0, 3'b000, 5'b00100, 3'b000, 1, 4'd0), ir, 0, 0, 0, 0);
    case (k)
      0, 1: begin
        add_step(cw(3'b010, 3'b010, 0, 3'b000, 5'b0, 3'b100, 0, 4'd0), ir, 0, 0, 0, 0);
        if (k == 0) add_step(cw(3'b001, 3'b010, 0, 3'b000, 5'b0, 3'b010, 0, alu), ir, 0, 0, 0, 0);
        else        add_step(cw(3'b000, 3'b000, 1, 3'b000, 5'b0, 3'b010, 0, alu), ir, 0, 0, 0, 0);
        add_step(cw(3'b100, 3'b100, 0, 3'b000, 5'b0, 3'b001, 0, 4'd0), ir, 0, 1, stop_last, 0);
      end
      2, 3, 4: begin
        add_step(cw(3'b010, 3'b001, 0, 3'b000, 5'b0, 3'b100, 0, 4'd0), ir, 0, 0, 0, 0);
        add_step(cw(3'b000, 3'b000, 1, 3'b000, 5'b0, 3'b010, 0, 4'd0), ir, 0, 0, 0, 0);
        if (k == 2) begin
          add_step(cw(3'b100, 3'b100, 0, 3'b000, 5'b0, 3'b001, 0, 4'd0), ir, 0, 1, stop_last, 0);
        end else begin
          add_step(cw(3'b000, 3'b000, 0, 3'b000, 5'b10000, 3'b001, 0, 4'd0), ir, 0, 0, 0, 0);
          if (k == 3) begin
            add_step(cw(3'b000, 3'b000, 0, 3'b000, 5'b01010, 3'b000, 0, 4'd0), ir, mem_waits, 0, 0, 0);
            add_step(cw(3'b100, 3'b100, 0, 3'b000, 5'b00100, 3'b000, 0, 4'd0), ir, 0, 1, stop_last, 0);
          end else begin
            add_step(cw(3'b100, 3'b010, 0, 3'b000, 5'b01000, 3'b000, 0, 4'd0), ir, 0, 0, 0, 0);
            add_step(cw(3'b000, 3'b000, 0, 3'b000, 5'b00001, 3'b000, 0, 4'd0), ir, mem_waits, 1, stop_last, 0);
          end
        end
      end
      default: add_step(cw(3'b000, 3'b000, 0, 3'b000, 5'b0, 3'b000, 0, 4'd0), ir, 0, 1, stop_last, 0);
    endcase
    halted = (k >= 6) || stop_last;
  endtask

  // Replays up to 'limit' schedule entries; called just after a rising edge.
  task automatic run_sched(input string name, input int limit);
    step_t s;
    int n;
    n = 0;
    while (sched.size() > 0 && n < limit) begin
      s = sched.pop_front();
      bus.IR = s.ir; bus.Mem_ready = s.mr; bus.Stop = s.stop;
      @(negedge clock);
      total++;
      if (observed() !== s.w) begin
        bad++;
        $display("[TB] FAIL %s cycle %0d: got %h want %h", name, n, observed(), s.w);
      end
      @(posedge clock); #1;
      n++;
    end
    sched.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0; bus.IR = 32'h0; bus.Mem_ready = 1'b0; bus.Stop = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    add_idle(1);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; bus.IR = 32'h19890000; bus.Mem_ready = 1'b1; bus.Stop = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    total++;
    if (observed() !== 24'h0) begin
      bad++; $display("[TB] FAIL reset_outputs: got %h want 000000", observed());
    end
    total++;
    if (bus.Illegal !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_illegal: got %b want 0", bus.Illegal);
    end
  endtask

  task automatic test_add();
    bit h;
    do_reset();
    build_instr(32'h19890000, 0, 0, 1'b0, h);
    build_instr(32'h19890000, 0, 0, 1'b0, h);
    run_sched("add", 1000);
  endtask

  task automatic test_ld_wait();
    bit h;
    do_reset();
    build_instr(32'h01080055, 0, 2, 1'b0, h);
    build_instr(32'h19890000, 0, 0, 1'b0, h);
    run_sched("ld_wait", 1000);
  endtask

  task automatic test_st_wait();
    bit h;
    do_reset();
    build_instr(32'h11080010, 0, 1, 1'b0, h);
    build_instr(32'h60880007, 0, 0, 1'b0, h);
    run_sched("st_wait", 1000);
  endtask

  task automatic test_fetch_wait();
    bit h;
    do_reset();
    build_instr(32'h21890000, 3, 0, 1'b0, h);
    build_instr(32'h08800003, 0, 0, 1'b0, h);
    run_sched("fetch_wait", 1000);
  endtask

  task automatic test_halt();
    bit h;
    do_reset();
    build_instr(32'hD8000000, 0, 0, 1'b0, h);
    add_idle(3);
    run_sched("halt", 1000);
    total++;
    if (bus.Illegal !== 1'b0) begin
      bad++; $display("[TB] FAIL halt_illegal: got %b want 0", bus.Illegal);
    end
  endtask

  task automatic test_illegal();
    bit h;
    do_reset();
    build_instr(32'hF8000000, 0, 0, 1'b0, h);
    add_idle(3);
    run_sched("illegal", 1000);
    total++;
    if (bus.Illegal !== 1'b1) begin
      bad++; $display("[TB] FAIL illegal_flag: got %b want 1", bus.Illegal);
    end
  endtask

  task automatic test_stop();
    bit h;
    do_reset();
    build_instr(32'h19890000, 0, 0, 1'b1, h);
    add_idle(3);
    run_sched("stop_add", 1000);
    do_reset();
    build_instr(32'hD8000000, 0, 0, 1'b1, h);
    add_idle(2);
    run_sched("stop_halt", 1000);
    do_reset();
    build_instr(32'hD0000000, 1, 0, 1'b1, h);
    add_idle(2);
    run_sched("stop_nop", 1000);
  endtask

  task automatic test_reset_mid();
    bit h;
    do_reset();
    build_instr(32'h01080055, 0, 5, 1'b0, h);
    // reset entry, T0, T1, T2, T3, T4, T5, then two T6 wait cycles
    run_sched("reset_mid_pre", 9);
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (observed() !== 24'h0) begin
      bad++; $display("[TB] FAIL reset_mid_async: got %h want 000000", observed());
    end
    @(posedge clock); #1 reset_n = 1'b1;
    add_idle(1);
    build_instr(32'h19890000, 0, 0, 1'b0, h);
    run_sched("reset_mid_restart", 1000);
  endtask

  task automatic test_random();
    logic [4:0] ops [11];
    logic [31:0] r;
    logic [31:0] ir;
    bit h;
    ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd13, 5'd14, 5'd26};
    do_reset();
    for (int i = 0; i < 25; i++) begin
      r  = $urandom();
      ir = {ops[$urandom_range(0, 10)], r[26:0]};
      build_instr(ir, $urandom_range(0, 2), $urandom_range(0, 2), (i == 24), h);
    end
    add_idle(2);
    run_sched("random", 100000);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_add();
    test_ld_wait();
    test_st_wait();
    test_fetch_wait();
    test_halt();
    test_illegal();
    test_stop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Multi-cycle control unit for the 32-bit RISC datapath. Decodes the opcode held in IR and steps a Moore state machine through fetch and execute micro-steps. Drives the register select-and-encode stage through the G/R strobes, and drives the PC, MAR/MDR, Y/Z, IR and ALU controls. Sits directly upstream of select-and-encode and the bus multiplexer; stalls on memory through a ready handshake.

## Interface
- OPW, 5, opcode width (IR[31:27])
- ALU_OPW, 4, ALU operation select width
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- IR  input  32  instruction register contents; Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15]
- Mem_ready  input  1  memory finished the pending Read/Write this cycle
- Stop  input  1  halt request, honoured at instruction boundary
- Run  output  1  high while executing, low in RESET/HALT
- Gsel  output  3  {Gra,Grb,Grc} to select-and-encode
- Rctl  output  3  {Rin,Rout,BAout} to select-and-encode
- Cout  output  1  sign-extended C field onto bus
- PCctl  output  3  {PCout,PCin,IncPC}
- MEMctl  output  5  {MARin,MDRin,MDRout,Read,Write}
- Zctl  output  3  {Yin,Zin,Zlowout}
- IRin  output  1  load IR from bus
- ALU_op  output  ALU_OPW  ALU operation
- Illegal  output  1  sticky; undefined opcode decoded

## Operation
- States: RESET, T0–T7, HALT. Outputs are a pure function of state and the latched opcode (Moore). Unlisted strobes are 0. Gsel is at most one-hot.
- RESET → T0 unconditionally.
- T0: PCout, MARin, IncPC, Zin, ALU_op=ADD.
- T1: Zlowout, PCin, Read, MDRin. Stays in T1 until Mem_ready=1. PCin is pulsed only on the first T1 cycle.
- T2: MDRout, IRin. T3: opcode is decoded from IR.
- Register ALU ops (add 00011, sub 00100, and 00101, or 00110):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, ALU_op, Zin.
  - T5: Zlowout, Gra, Rin → T0.
- Immediate ALU ops (addi 01100, andi 01101, ori 01110): as the register ops, except T4 uses Cout instead of Grc/Rout.
- ldi 00001: T3 Grb, BAout, Yin; T4 Cout, ADD, Zin; T5 Zlowout, Gra, Rin → T0.
- ld 00000:
  - T3–T4: as ldi.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin; wait for Mem_ready.
  - T7: MDRout, Gra, Rin → T0.
- st 00010:
  - T3–T5: as ld.
  - T6: Gra, Rout, MDRin with Read=0 (bus source).
  - T7: Write; wait for Mem_ready → T0.
- nop 11010: T3 → T0. halt 11011: T3 → HALT.
- Any other opcode: set Illegal, T3 → HALT.
- Stop=1 sampled on the final step of an instruction: go to HALT instead of T0. HALT is left only by reset.
- ALU codes: ADD=0, SUB=1, AND=2, OR=3. ALU_op=0 when unused.

## Timing
- While reset_n=0: state RESET and all outputs 0, including Run and Illegal. The first edge after deassertion enters T0. Run=1 in T0–T7.
- Reset asserted mid-instruction (including during a memory wait) aborts immediately. Strobes drop asynchronously.
- Mem_ready is sampled at the rising edge. If Mem_ready is high in the first T1/T6/T7-wait cycle, there are zero wait states. Each low sample adds one cycle with the strobes held, except that PCin is not repeated.
- Latency at zero wait: ALU/ldi 6 cycles, ld/st 8, nop 4, halt 4 to HALT.
- Stop has no effect mid-instruction. Stop together with the halt opcode gives HALT, with no double action.

## Structure
- Shared package `cpu_pkg`: opcode constants, ALU_* codes, state enum, and bit-index constants for the MEMctl/PCctl/Zctl/Rctl/Gsel vectors. The top-level datapath uses the same package.
- One sub-module, `op_decode`: combinational opcode → instruction class (ALU_R, ALU_I, LDI, LD, ST, NOP, HALT, BAD) plus ALU_op. The sequencer holds the state register and output decode.

## Test plan
- Reset, deassert, Mem_ready tied 1, IR=0x19890000 (add R3,R1,R2) → T0..T5 in 6 cycles. T4: Gsel=001, Rout=1, ALU_op=0. T5: Gra=1, Rin=1, Zlowout=1.
- IR=0x01080055 (ld R2,0x55(R1)), Mem_ready low for 2 cycles in T6 → Read/MDRin held 3 cycles, then T7 with Gsel=100, Rin=1. Total 10 cycles.
- st with Mem_ready low for 1 cycle in T7 → Write held 2 cycles. MDRin=1 with Read=0 in T6.
- Fetch with Mem_ready low for 3 cycles → PCin high for exactly 1 cycle; IRin after the wait.
- IR=0xD8000000 (halt) → HALT after T3, Run=0. IR=0xF8000000 → Illegal=1 and HALT. Stop=1 during T5 of an add → HALT with no next fetch.
- reset_n pulsed low during the T6 wait of ld → all outputs 0 immediately. Restart at T0 on the first edge after release.
